// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared types and helpers for the tick scheduler.
//   state_e : run/stop state of the shared prescaler
//   ch_w()  : width of a channel index; never 0, even for a single channel
package tick_sched_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: channel-period configuration write port (valid/ready).
//   cfg_valid  host -> sched  write request
//   cfg_ready  sched -> host  write accepted on valid & ready
//   cfg_ch     host -> sched  target channel; out-of-range values are dropped
//   cfg_period host -> sched  half-period in base ticks, 0 = channel off
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16
) ();

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [ch_w(NUM_CH)-1:0]   cfg_ch;
  logic [PERIOD_W-1:0]       cfg_period;

  modport master (output cfg_valid, output cfg_ch, output cfg_period, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_period, output cfg_ready);

endinterface

// File: rtl/tick_sched_channel.sv
// tick_sched_channel: one divider channel clocked by the shared base tick.
//   clk, rst_n   clock / async active-low reset
//   tick         base tick pulse
//   clear        phase restart: counter and output to 0, period kept
//   load         write load_period, restart phase
//   load_period  new half-period (0 = off)
//   ch_out       square-wave output, toggles every period base ticks
//   ch_pulse     (TICK_SCHED_PULSE_EN only) 1-cycle pulse with each 0->1 of ch_out
module tick_sched_channel #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                clear,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_period,
  output logic                ch_out
`ifdef TICK_SCHED_PULSE_EN
  ,
  output logic                ch_pulse
`endif
);

  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] term;
  logic                wrap;

  // Terminal count kept in PERIOD_W bits; period 0 is handled before it is used.
  assign term = period_q - PERIOD_W'(1);
  assign wrap = (period_q != '0) && (cnt_q == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      ch_out   <= 1'b0;
    end else if (clear) begin
      cnt_q    <= '0;
      ch_out   <= 1'b0;
    end else if (load) begin
      period_q <= load_period;
      cnt_q    <= '0;
      ch_out   <= 1'b0;
    end else if (tick) begin
      if (period_q == '0) begin
        cnt_q  <= '0;
        ch_out <= 1'b0;
      end else if (wrap) begin
        cnt_q  <= '0;
        ch_out <= ~ch_out;
      end else begin
        cnt_q  <= cnt_q + PERIOD_W'(1);
      end
    end
  end

`ifdef TICK_SCHED_PULSE_EN
  // Registered alongside ch_out so the pulse lines up with the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ch_pulse <= 1'b0;
    else        ch_pulse <= tick && !clear && !load && wrap && !ch_out;
  end
`endif

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: one shared prescaler (clk -> base tick) driving NUM_CH
// small period dividers with square-wave outputs.
//   clk, rst_n  clock / async active-low reset
//   run_en      level: 1 = run, 0 = stop (prescaler held, channel phase kept)
//   sync_req    1-cycle pulse: restart prescaler and clear every channel phase
//   cfg         tick_scheduler_if.slave period write port
//   base_tick   1-cycle pulse at prescaler terminal count
//   ch_out      per-channel square waves
//   ch_pulse    per-channel rising-edge pulses, only with TICK_SCHED_PULSE_EN defined
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PRESCALE_W   = 24,
  parameter int PRESCALE_MAX = 12000 - 1,
  parameter int PERIOD_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  input  logic               sync_req,
  tick_scheduler_if.slave    cfg,
  output logic               base_tick,
  output logic [NUM_CH-1:0]  ch_out
`ifdef TICK_SCHED_PULSE_EN
  ,
  output logic [NUM_CH-1:0]  ch_pulse
`endif
);

  localparam int                  CH_W    = ch_w(NUM_CH);
  localparam logic [PRESCALE_W-1:0] PRE_TC = PRESCALE_W'(PRESCALE_MAX);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STOP;
    else        state_q <= state_d;
  end

  // sync_req never changes state; it only restarts phase.
  // Writes are refused while a tick or sync is being applied so a load never
  // races a channel update in the same cycle.
  always_comb begin
    state_d       = state_q;
    base_tick     = 1'b0;
    cfg.cfg_ready = 1'b1;
    case (state_q)
      ST_STOP: if (run_en)  state_d = ST_RUN;
      ST_RUN:  if (!run_en) state_d = ST_STOP;
      default:              state_d = ST_STOP;
    endcase
    base_tick     = (state_q == ST_RUN) && (pre_q == PRE_TC) && !sync_req;
    cfg.cfg_ready = !base_tick && !sync_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             pre_q <= '0;
    else if (sync_req || state_q != ST_RUN) pre_q <= '0;
    else if (pre_q == PRE_TC)               pre_q <= '0;
    else                                    pre_q <= pre_q + PRESCALE_W'(1);
  end

  assign wr = cfg.cfg_valid && cfg.cfg_ready;

  // Out-of-range cfg_ch matches no instance, so the write is accepted and dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_sched_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (base_tick),
      .clear       (sync_req),
      .load        (wr && (cfg.cfg_ch == CH_W'(i))),
      .load_period (cfg.cfg_period),
      .ch_out      (ch_out[i])
`ifdef TICK_SCHED_PULSE_EN
      ,
      .ch_pulse    (ch_pulse[i])
`endif
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int NUM_CH       = 4;
  localparam int PERIOD_W     = 8;
  localparam int PRESCALE_W   = 4;
  localparam int PRESCALE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run_en = 1'b0;
  logic              sync_req = 1'b0;
  logic              base_tick;
  logic [NUM_CH-1:0] ch_out;
`ifdef TICK_SCHED_PULSE_EN
  logic [NUM_CH-1:0] ch_pulse;
`endif

  int n_chk = 0;
  int n_err = 0;

  tick_scheduler_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) cfg_if ();

  tick_scheduler #(
    .NUM_CH(NUM_CH), .PRESCALE_W(PRESCALE_W),
    .PRESCALE_MAX(PRESCALE_MAX), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .sync_req  (sync_req),
    .cfg       (cfg_if),
    .base_tick (base_tick),
    .ch_out    (ch_out)
`ifdef TICK_SCHED_PULSE_EN
    ,
    .ch_pulse  (ch_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic cfg_wr(input int ch, input int p);
    int n = 0;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_period = 8'(p);
    @(negedge clk);
    while (!cfg_if.cfg_ready && n < 20) begin @(negedge clk); n++; end
    chk("cfg_accept", 32'(cfg_if.cfg_ready), 1);
    @(posedge clk); #1;
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge of a base_tick cycle.
  task automatic wait_bt();
    int n = 0;
    @(negedge clk);
    while (!base_tick && n < 16) begin @(negedge clk); n++; end
    chk("bt_wait", 32'(base_tick), 1);
  endtask

  initial begin
    int first_bt, n_bt, n_tg, n_pl, bad, ones, frz;
    int tg[4];
    logic prev, prev_bt;
    logic [NUM_CH-1:0] snap;

    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_period = '0;

    // reset state
    #1;
    chk("rst_ch_out", 32'(ch_out), 0);
    chk("rst_bt", 32'(base_tick), 0);
    chk("rst_rdy", 32'(cfg_if.cfg_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ch0 period 2, ch1 period 1, then run
    cfg_wr(0, 2);
    cfg_wr(1, 1);
    run_en = 1'b1;
    first_bt = -1; n_bt = 0; n_tg = 0; n_pl = 0; prev = ch_out[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (base_tick) begin if (first_bt < 0) first_bt = k; n_bt++; end
      if (ch_out[0] != prev) begin if (n_tg < 4) tg[n_tg] = k; n_tg++; end
      prev = ch_out[0];
`ifdef TICK_SCHED_PULSE_EN
      if (ch_pulse[0]) n_pl++;
`endif
    end
    chk("bt_first", 32'(first_bt), 4);
    chk("bt_count", 32'(n_bt), 9);
    chk("ch0_ntg", 32'(n_tg), 4);
    chk("ch0_tg0", 32'(tg[0]), 9);
    chk("ch0_tg1", 32'(tg[1]), 17);
    chk("ch0_tg2", 32'(tg[2]), 25);
    chk("ch0_tg3", 32'(tg[3]), 33);
`ifdef TICK_SCHED_PULSE_EN
    chk("ch0_pulses", 32'(n_pl), 2);
`endif

    // ch1 off while running, ch2 period 1
    cfg_wr(1, 0);
    cfg_wr(2, 1);
    wait_bt();
    prev = ch_out[2]; prev_bt = base_tick; bad = 0; ones = 0; n_tg = 0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      if ((ch_out[2] != prev) != prev_bt) bad++;
      if (ch_out[2] != prev) n_tg++;
      if (ch_out[1]) ones++;
      prev = ch_out[2]; prev_bt = base_tick;
    end
    chk("ch2_follow", 32'(bad), 0);
    chk("ch2_ntg", 32'(n_tg), 8);
    chk("ch1_off", 32'(ones), 0);

    // write held across a base_tick, then stop/resume mid-phase
    wait_bt();
    chk("rdy_bt", 32'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd3; cfg_if.cfg_period = 8'd5;
    #1 chk("rdy_bt_v", 32'(cfg_if.cfg_ready), 0);
    bad = 0; n_bt = 0; frz = 0; first_bt = -1; snap = '0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 1) chk("rdy_after_bt", 32'(cfg_if.cfg_ready), 1);
      if (j == 2) cfg_if.cfg_valid = 1'b0;
      if (j >= 2 && j <= 20 && ch_out[3]) bad++;
      if (j == 21) chk("ch3_rise", 32'(ch_out[3]), 1);
      if (j >= 31 && j <= 40) begin
        if (base_tick) n_bt++;
        if (ch_out != snap) frz++;
      end
      if (j >= 41 && base_tick && first_bt < 0) first_bt = j;
      if (j == 52) chk("ch3_hold", 32'(ch_out[3]), 1);
      if (j == 53) chk("ch3_fall", 32'(ch_out[3]), 0);
      if (j == 30) begin run_en = 1'b0; snap = ch_out; end
      if (j == 40) run_en = 1'b1;
    end
    chk("ch3_early", 32'(bad), 0);
    chk("stop_no_bt", 32'(n_bt), 0);
    chk("stop_frozen", 32'(frz), 0);
    chk("resume_bt", 32'(first_bt), 44);

    // sync with ch0=2, ch3=3; sync lands on a would-be base_tick cycle
    cfg_wr(3, 3);
    wait_bt();
    repeat (4) @(negedge clk);
    sync_req = 1'b1;
    #1;
    chk("sync_bt_sup", 32'(base_tick), 0);
    chk("sync_rdy", 32'(cfg_if.cfg_ready), 0);
    ones = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin sync_req = 1'b0; chk("sync_clr", 32'(ch_out), 0); end
      if (k == 4) chk("ch2_pre", 32'(ch_out[2]), 0);
      if (k == 5) chk("ch2_post", 32'(ch_out[2]), 1);
      if (k == 8) chk("ch0_pre", 32'(ch_out[0]), 0);
      if (k == 9) chk("ch0_rise", 32'(ch_out[0]), 1);
      if (k == 12) chk("ch3_pre", 32'(ch_out[3]), 0);
      if (k == 13) chk("ch3_rise2", 32'(ch_out[3]), 1);
      if (ch_out[1]) ones++;
    end
    chk("ch1_off2", 32'(ones), 0);

    // asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ch_out", 32'(ch_out), 0);
    chk("arst_bt", 32'(base_tick), 0);
    chk("arst_rdy", 32'(cfg_if.cfg_ready), 1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ch_out != '0 || base_tick || !cfg_if.cfg_ready) bad++;
    end
    chk("arst_hold", 32'(bad), 0);
    rst_n = 1'b1;
    n_bt = 0; ones = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (base_tick) n_bt++;
      if (ch_out != '0) ones++;
    end
    chk("post_rst_bt", 32'(n_bt), 7);
    chk("post_rst_periods_lost", 32'(ones), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
